// File: rtl/fifo_sample_unpack.sv
// Capture-FIFO byte reader: rebuilds 32-bit packed words, streams 10-bit samples.
// Optional clip counter is built when FIFO_UNPACK_CLIP_EN is defined.
module fifo_sample_unpack #(
    parameter int CNT_W      = 32,
    parameter int CLIP_CNT_W = 16
) (
    input  logic                  fifo_read_fifoclk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [CNT_W-1:0]      cfg_samples_i,
    input  logic                  fifo_read_fifoempty,
    output logic                  fifo_read_fifoen,
    input  logic [7:0]            fifo_read_data,
    output logic [9:0]            sample_o,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic                  sample_trig_o,
    output logic                  sample_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  trig_seen_o,
    output logic [CLIP_CNT_W-1:0] clip_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cfg;
    logic [CNT_W+1:0]   r_cover;
    logic [1:0]         r_strb_cnt;
    logic               r_inflight;
    logic [31:0]        r_asm;
    logic [2:0]         r_asm_cnt;
    logic [29:0]        r_buf;
    logic               r_buf_valid;
    logic [1:0]         r_buf_idx;
    logic [1:0]         r_buf_tidx;
    logic               r_tag_taken;
    logic [CNT_W-1:0]   r_emit;
    logic               r_trig_seen;

    logic               w_start;
    logic               w_valid;
    logic               w_xfer;
    logic               w_last;
    logic               w_fin;
    logic               w_buf_free;
    logic               w_move;
    logic [2:0]         w_occ;
    logic               w_quota;
    logic [9:0]         w_field;

    assign w_start    = start_i && !abort_i && (r_state == S_IDLE);
    assign w_valid    = (r_state == S_RUN) && r_buf_valid;
    assign w_xfer     = w_valid && sample_ready_i;
    assign w_last     = w_valid &&
                        (({1'b0, r_emit} + 1'b1) == {1'b0, r_cfg});
    assign w_fin      = w_xfer && w_last;
    assign w_buf_free = !r_buf_valid ||
                        (w_xfer && (r_buf_idx == 2'd2) && !w_last);
    assign w_move     = (r_state == S_RUN) && !abort_i &&
                        (r_asm_cnt == 3'd4) && w_buf_free;
    // Bytes already held plus the one still in the read pipeline.
    assign w_occ      = (w_move ? 3'd0 : r_asm_cnt) + {2'b00, r_inflight};
    // Quota tracked as samples covered by fully strobed words.
    assign w_quota    = r_cover < {2'b00, r_cfg};

    assign fifo_read_fifoen = (r_state == S_RUN) && !abort_i && !w_fin &&
                              !fifo_read_fifoempty && w_quota &&
                              (w_occ < 3'd4);

    always_comb begin
        w_field = r_buf[9:0];
        unique case (r_buf_idx)
            2'd1:    w_field = r_buf[19:10];
            2'd2:    w_field = r_buf[29:20];
            default: w_field = r_buf[9:0];
        endcase
    end

    assign sample_o       = w_valid ? w_field : 10'd0;
    assign sample_valid_o = w_valid;
    assign sample_trig_o  = w_valid && (r_buf_tidx == r_buf_idx);
    assign sample_last_o  = w_last;
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = (r_state == S_DONE) && !abort_i;
    assign trig_seen_o    = r_trig_seen;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start)
                    w_state_nxt = (cfg_samples_i == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (abort_i)
                    w_state_nxt = S_IDLE;
                else if (w_fin)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge fifo_read_fifoclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge fifo_read_fifoclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg       <= '0;
            r_cover     <= '0;
            r_strb_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_asm       <= '0;
            r_asm_cnt   <= '0;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_buf_idx   <= '0;
            r_buf_tidx  <= 2'd3;
            r_tag_taken <= 1'b0;
            r_emit      <= '0;
            r_trig_seen <= 1'b0;
        end else if (w_start) begin
            r_cfg       <= cfg_samples_i;
            r_cover     <= '0;
            r_strb_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_asm_cnt   <= '0;
            r_buf_valid <= 1'b0;
            r_buf_idx   <= '0;
            r_buf_tidx  <= 2'd3;
            r_tag_taken <= 1'b0;
            r_emit      <= '0;
            r_trig_seen <= 1'b0;
        end else begin
            if (fifo_read_fifoen) begin
                r_strb_cnt <= r_strb_cnt + 2'd1;
                if (r_strb_cnt == 2'd3)
                    r_cover <= r_cover + (CNT_W+2)'(3);
            end
            r_inflight <= fifo_read_fifoen;
            if (r_inflight) begin
                r_asm     <= {r_asm[23:0], fifo_read_data};
                r_asm_cnt <= (w_move ? 3'd0 : r_asm_cnt) + 3'd1;
            end else if (w_move) begin
                r_asm_cnt <= 3'd0;
            end
            if (w_move) begin
                r_buf       <= r_asm[29:0];
                r_buf_valid <= 1'b1;
                r_buf_idx   <= 2'd0;
                r_buf_tidx  <= (!r_tag_taken) ? r_asm[31:30] : 2'd3;
                r_tag_taken <= r_tag_taken || (r_asm[31:30] != 2'd3);
            end else if (w_xfer) begin
                r_buf_idx <= r_buf_idx + 2'd1;
                if (r_buf_idx == 2'd2)
                    r_buf_valid <= 1'b0;
            end
            if (w_xfer) begin
                r_emit <= r_emit + 1'b1;
                if (sample_trig_o)
                    r_trig_seen <= 1'b1;
            end
            // Leaving RUN drops any partial word and the in-flight byte.
            if ((r_state != S_RUN) || abort_i || w_fin) begin
                r_inflight  <= 1'b0;
                r_asm_cnt   <= '0;
                r_buf_valid <= 1'b0;
            end
        end
    end

`ifdef FIFO_UNPACK_CLIP_EN
    logic [CLIP_CNT_W-1:0] r_clip;

    always_ff @(posedge fifo_read_fifoclk or negedge reset_n) begin
        if (!reset_n) begin
            r_clip <= '0;
        end else if (w_start) begin
            r_clip <= '0;
        end else if (w_xfer && ((w_field == 10'h000) || (w_field == 10'h3FF))
                     && !(&r_clip)) begin
            r_clip <= r_clip + 1'b1;
        end
    end

    assign clip_count_o = r_clip;
`else
    assign clip_count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_sample_unpack.sv
// Directed bench for fifo_sample_unpack: byte FIFO model plus sample scoreboard.
// Expected clip count follows FIFO_UNPACK_CLIP_EN.
module tb_fifo_sample_unpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg;
    logic        fifo_empty;
    logic        fifoen;
    logic [7:0]  rdata = 8'd0;
    logic [9:0]  sample;
    logic        valid;
    logic        ready;
    logic        trig;
    logic        last;
    logic        busy;
    logic        done;
    logic        trig_seen;
    logic [15:0] clip;

    logic [7:0]  mem [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          bad_rd = 0;

    logic [11:0] exp_q[$];
    int          exp_strobes;
    int          exp_clip;
    logic        exp_trig;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done;
    int          n_busy;
    logic        hold_v = 1'b0;
    logic [11:0] held;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifoen) begin
            if (rd_ptr == wr_ptr) begin
                bad_rd = bad_rd + 1;
            end else begin
                rdata <= mem[rd_ptr];
                rd_ptr = rd_ptr + 1;
            end
        end
    end

    fifo_sample_unpack dut (
        .fifo_read_fifoclk   (clk),
        .reset_n             (rst_n),
        .start_i             (start),
        .abort_i             (abort),
        .cfg_samples_i       (cfg),
        .fifo_read_fifoempty (fifo_empty),
        .fifo_read_fifoen    (fifoen),
        .fifo_read_data      (rdata),
        .sample_o            (sample),
        .sample_valid_o      (valid),
        .sample_ready_i      (ready),
        .sample_trig_o       (trig),
        .sample_last_o       (last),
        .busy_o              (busy),
        .done_o              (done),
        .trig_seen_o         (trig_seen),
        .clip_count_o        (clip)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            mem[wr_ptr] = w[31-8*k -: 8];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Expected samples for a run of n samples over the bytes not yet read.
    task automatic expect_run(input int n);
        int          got;
        int          tidx;
        logic        taken;
        logic [31:0] w;
        logic [9:0]  s;
        got = 0;
        taken = 1'b0;
        exp_trig = 1'b0;
        exp_clip = 0;
        exp_q.delete();
        for (int wi = 0; got < n; wi++) begin
            w = {mem[rd_ptr+4*wi], mem[rd_ptr+4*wi+1],
                 mem[rd_ptr+4*wi+2], mem[rd_ptr+4*wi+3]};
            tidx = 3;
            if (!taken && w[31:30] != 2'd3) begin
                tidx = int'(w[31:30]);
                taken = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                if (got < n) begin
                    s = w[10*k +: 10];
                    exp_q.push_back({s, k == tidx, got == n - 1});
                    if (k == tidx) exp_trig = 1'b1;
                    if (s == 10'h000 || s == 10'h3FF) exp_clip++;
                    got++;
                end
            end
        end
        exp_strobes = 4 * ((n + 2) / 3);
`ifndef FIFO_UNPACK_CLIP_EN
        exp_clip = 0;
`endif
    endtask

    task automatic step(input logic rdy, input logic st, input logic ab);
        logic [11:0] e;
        @(negedge clk);
        ready = rdy;
        start = st;
        abort = ab;
        #1;
        if (done) n_done++;
        if (busy) n_busy++;
        if (hold_v)
            chk("stall_hold", {valid, sample, trig, last}, {1'b1, held});
        hold_v = 1'b0;
        if (valid) begin
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_sample", {sample, trig, last}, 12'hFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample", {sample, trig, last}, e);
                end
            end else begin
                hold_v = 1'b1;
                held = {sample, trig, last};
            end
        end
    endtask

    task automatic run_idle(input int budget);
        int i;
        i = 0;
        do begin
            step(1'b1, 1'b0, 1'b0);
            i++;
        end while (busy && i < budget);
        chk("run_timeout", busy, 1'b0);
    endtask

    initial begin
        int s0;
        int nv;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        cfg = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {fifoen, sample, valid, trig, last, busy, done,
                           trig_seen, clip}, '0);
        rst_n = 1'b1;

        // 1: single word, trigger on second sample
        push_word(32'h40100401);
        expect_run(3);
        cfg = 32'd3;
        s0 = rd_ptr;
        n_done = 0;
        step(1'b1, 1'b1, 1'b0);
        run_idle(40);
        chk("t1_done", n_done, 1);
        chk("t1_strobes", rd_ptr - s0, exp_strobes);
        chk("t1_trig_seen", trig_seen, exp_trig);
        chk("t1_left", exp_q.size(), 0);

        // 2: cfg=4 over two words, tail of second word dropped
        push_word(32'hC0300C03);
        push_word(32'h87654321);
        expect_run(4);
        cfg = 32'd4;
        s0 = rd_ptr;
        n_done = 0;
        step(1'b1, 1'b1, 1'b0);
        run_idle(60);
        chk("t2_done", n_done, 1);
        chk("t2_strobes", rd_ptr - s0, 8);
        chk("t2_trig_seen", trig_seen, exp_trig);
        chk("t2_left", exp_q.size(), 0);

        // 3: ready low for 10 cycles after the first sample
        push_word(32'h12345678);
        push_word(32'h3ABCDEF0);
        expect_run(6);
        cfg = 32'd6;
        s0 = rd_ptr;
        n_done = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30 && exp_q.size() > 5; i++)
            step(1'b1, 1'b0, 1'b0);
        chk("t3_first", exp_q.size(), 5);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (valid) nv++;
        end
        chk("t3_valid_stall", nv, 10);
        run_idle(60);
        chk("t3_done", n_done, 1);
        chk("t3_strobes", rd_ptr - s0, exp_strobes);
        chk("t3_left", exp_q.size(), 0);

        // 4: zero-length run
        cfg = 32'd0;
        s0 = rd_ptr;
        n_done = 0;
        n_busy = 0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_done_now", done, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_done", n_done, 1);
        chk("t4_busy", n_busy, 1);
        chk("t4_strobes", rd_ptr - s0, 0);

        // 5: abort after two bytes, then a fresh run
        push_word(32'h40100401);
        cfg = 32'd3;
        s0 = rd_ptr;
        n_done = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && rd_ptr - s0 < 1; i++)
            step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_idle", {busy, valid, fifoen}, 3'b000);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_no_done", n_done, 0);
        chk("t5_strobes", rd_ptr - s0, 2);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_abort_wins", busy, 1'b0);
        push_byte(8'hAB);
        push_byte(8'hCD);
        expect_run(2);
        cfg = 32'd2;
        s0 = rd_ptr;
        step(1'b1, 1'b1, 1'b0);
        run_idle(40);
        chk("t5_done", n_done, 1);
        chk("t5_strobes2", rd_ptr - s0, exp_strobes);
        chk("t5_left", exp_q.size(), 0);

        // 6: full-scale and zero samples
        push_word(32'hFFFFFFFF);
        push_word(32'h00000000);
        expect_run(6);
        cfg = 32'd6;
        s0 = rd_ptr;
        n_done = 0;
        step(1'b1, 1'b1, 1'b0);
        run_idle(60);
        chk("t6_done", n_done, 1);
        chk("t6_clip", clip, exp_clip);
        chk("t6_trig_seen", trig_seen, exp_trig);
        chk("t6_strobes", rd_ptr - s0, 8);
        chk("t6_left", exp_q.size(), 0);
        chk("no_empty_reads", bad_rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
